ascon_perm_unrolled: RTL and testbench

- Parametrised ASCON permutation engine that applies UNROLL rounds per clock and runs its own round counter.
- Executes p^a (12 rounds) or p^b (6/8 rounds), selected per operation, under a start/done handshake.
- Sits between the AEAD controller and the state register file.
- Replaces fixed two-round-per-cycle datapaths whose round constants are sequenced externally.

---
 rtl/ascon_pkg.sv | 50 +++++
 rtl/ascon_round.sv | 50 +++++
 rtl/ascon_perm_unrolled.sv | 155 +++++++++++++++
 tb/tb_ascon_perm_unrolled.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Purpose : shared types and helpers for the unrolled ASCON permutation engine.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
package ascon_pkg;

    // Upper bound on rounds; the constant schedule of a p^n permutation
    // starts at index ASCON_MAX_ROUNDS - n so all variants end on the same constant.
    localparam int ASCON_MAX_ROUNDS = 12;

    // 320-bit permutation state, x0 in the most significant word.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Round-constant byte for schedule index idx: high nibble counts down
    // from F while the low nibble counts up (0xF0, 0xE1, 0xD2, ...).
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'hF - idx, idx};
    endfunction

    // Only divisors of 12 (excluding 12 itself) are supported per-cycle unroll factors.
    function automatic bit unroll_is_legal(input int unroll);
        return (unroll == 1) || (unroll == 2) || (unroll == 3) ||
               (unroll == 4) || (unroll == 6);
    endfunction

    // Bit n set when a request for n rounds can be served: non-zero, within
    // the bound and an exact multiple of the unroll factor.
    function automatic logic [15:0] nr_legal_mask(input int unroll, input int max_rounds);
        logic [15:0] m;
        m = '0;
        for (int n = 1; n < 16; n++) begin
            if ((n <= max_rounds) && ((n % unroll) == 0)) begin
                m[n] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// Purpose : one combinational ASCON round (constant add, 5-bit S-box layer, linear diffusion).
// Latency : 0 cycles, purely combinational.
// Backpr. : none; ports s_i (state in), rc_i (round-constant byte), s_o (state out).
module ascon_round
    import ascon_pkg::*;
(
    input  state_t      s_i,
    input  logic [7:0]  rc_i,
    output state_t      s_o
);

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    always_comb begin
        // Constant addition into the low byte of x2, then the S-box input mixing.
        a0 = s_i.x0 ^ s_i.x4;
        a1 = s_i.x1;
        a2 = s_i.x2 ^ {56'd0, rc_i} ^ s_i.x1;
        a3 = s_i.x3;
        a4 = s_i.x4 ^ s_i.x3;

        // Chi-like nonlinear core, bit-sliced across all 64 columns.
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        // S-box output mixing.
        c0 = b0 ^ b4;
        c1 = b1 ^ b0;
        c2 = ~b2;
        c3 = b3 ^ b2;
        c4 = b4;

        // Per-word linear diffusion.
        s_o.x0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
        s_o.x1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
        s_o.x2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
        s_o.x3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
        s_o.x4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);
    end

endmodule

// File: rtl/ascon_perm_unrolled.sv
// Purpose : ASCON permutation p^n applying UNROLL rounds per clock with its own round counter.
// Latency : done_o pulses nr_i/UNROLL + 1 cycles after the cycle start_i is accepted.
// Backpr. : start_i is taken only in IDLE; requests in RUN/DONE are dropped, illegal nr_i pulses err_o.
// Ports   : clk, rst (async, active-high); start_i, nr_i[3:0], x0_i..x4_i[63:0] in;
//           busy_o, done_o, err_o, x0_o..x4_o[63:0] out.
// Option  : define ASCON_PERM_OUTPUT_GATE_EN to drive x*_o from a result register loaded
//           only on completion, hiding intermediate round states.
module ascon_perm_unrolled
    import ascon_pkg::*;
#(
    parameter int UNROLL     = 2,
    parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [3:0]  nr_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o
);

    if (!unroll_is_legal(UNROLL) || (MAX_ROUNDS > 15) || (MAX_ROUNDS < 1)) begin : g_bad_cfg
        $error("ascon_perm_unrolled: UNROLL must be 1, 2, 3, 4 or 6 and MAX_ROUNDS 1..15");
    end

    localparam logic [15:0] NR_LEGAL = nr_legal_mask(UNROLL, MAX_ROUNDS);
    localparam logic [3:0]  MAX_R    = 4'(MAX_ROUNDS);
    localparam logic [3:0]  STEP     = 4'(UNROLL);

    fsm_t        fsm_q, fsm_d;
    state_t      st_q, st_d;
    logic [3:0]  r_q, r_d;
    logic        err_q, err_d;

    logic        nr_legal;
    logic        last_step;
    state_t      chain [UNROLL+1];
    state_t      out_view;

    assign nr_legal  = NR_LEGAL[nr_i];
    // Widened compare so r + UNROLL cannot wrap before matching the bound.
    assign last_step = (({1'b0, r_q} + {1'b0, STEP}) == {1'b0, MAX_R});

    // Round chain: stage k uses schedule index r + k.
    assign chain[0] = st_q;
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [3:0] c_idx;
        assign c_idx = r_q + 4'(k);
        ascon_round u_round (
            .s_i  (chain[k]),
            .rc_i (round_const(c_idx)),
            .s_o  (chain[k+1])
        );
    end

    // State register process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= ST_IDLE;
            st_q  <= '0;
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            r_q   <= r_d;
            err_q <= err_d;
        end
    end

    // Next-state process.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (start_i && nr_legal) fsm_d = ST_RUN;
            ST_RUN:  if (last_step)           fsm_d = ST_DONE;
            ST_DONE:                          fsm_d = ST_IDLE;
            default:                          fsm_d = ST_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        st_d  = st_q;
        r_d   = r_q;
        err_d = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (nr_legal) begin
                        st_d = {x0_i, x1_i, x2_i, x3_i, x4_i};
                        r_d  = MAX_R - nr_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                st_d = chain[UNROLL];
                r_d  = r_q + STEP;
            end
            default: ;
        endcase
    end

    // Output process.
    always_comb begin
        busy_o = (fsm_q == ST_RUN);
        done_o = (fsm_q == ST_DONE);
    end

`ifdef ASCON_PERM_OUTPUT_GATE_EN
    state_t out_q, out_d;

    // Result register captures the final chain output on the RUN->DONE edge,
    // the same edge that commits it to the state register.
    always_comb begin
        out_d = out_q;
        if ((fsm_q == ST_RUN) && last_step) begin
            out_d = chain[UNROLL];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_view = out_q;
`else
    assign out_view = st_q;
`endif

    assign err_o = err_q;
    assign x0_o  = out_view.x0;
    assign x1_o  = out_view.x1;
    assign x2_o  = out_view.x2;
    assign x3_o  = out_view.x3;
    assign x4_o  = out_view.x4;

endmodule

// File: tb/tb_ascon_perm_unrolled.sv
// Purpose : directed self-checking bench for ascon_perm_unrolled (UNROLL=2 and UNROLL=3 instances).
// Latency : expectations computed by a table-driven S-box reference of the permutation.
// Backpr. : exercises start during RUN/DONE, illegal nr, and async reset mid-run.
module tb_ascon_perm_unrolled;

    localparam logic [63:0] IV = 64'h80400c0600000000;

    // ASCON 5-bit S-box, index = {x0,x1,x2,x3,x4} column bits, x0 as MSB.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    logic [3:0]  nr, nr3;
    logic [63:0] xi0, xi1, xi2, xi3, xi4;
    logic        busy, done, err;
    logic [63:0] xo0, xo1, xo2, xo3, xo4;
    logic        busy3, done3, err3;
    logic [63:0] xp0, xp1, xp2, xp3, xp4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ascon_perm_unrolled #(.UNROLL(2), .MAX_ROUNDS(12)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start), .nr_i(nr),
        .x0_i(xi0), .x1_i(xi1), .x2_i(xi2), .x3_i(xi3), .x4_i(xi4),
        .busy_o(busy), .done_o(done), .err_o(err),
        .x0_o(xo0), .x1_o(xo1), .x2_o(xo2), .x3_o(xo3), .x4_o(xo4)
    );

    ascon_perm_unrolled #(.UNROLL(3), .MAX_ROUNDS(12)) u_dut3 (
        .clk(clk), .rst(rst), .start_i(start3), .nr_i(nr3),
        .x0_i(xi0), .x1_i(xi1), .x2_i(xi2), .x3_i(xi3), .x4_i(xi4),
        .busy_o(busy3), .done_o(done3), .err_o(err3),
        .x0_o(xp0), .x1_o(xp1), .x2_o(xp2), .x3_o(xp3), .x4_o(xp4)
    );

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    // Reference: count rounds starting at schedule index first_c.
    function automatic logic [319:0] perm_model(input logic [319:0] s, input int first_c, input int count);
        logic [63:0] w [5];
        logic [63:0] t [5];
        logic [4:0]  col;
        logic [4:0]  v;
        logic [7:0]  rc;
        for (int i = 0; i < 5; i++) w[i] = s[319-64*i -: 64];
        for (int r = 0; r < count; r++) begin
            rc = 8'hF0 - 8'(15 * (first_c + r));
            w[2][7:0] = w[2][7:0] ^ rc;
            for (int b = 0; b < 64; b++) begin
                col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
                v   = SBOX[col];
                for (int i = 0; i < 5; i++) t[i][b] = v[4-i];
            end
            w[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
            w[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
            w[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
            w[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
            w[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        end
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    function automatic logic [319:0] dut_out();
        return {xo0, xo1, xo2, xo3, xo4};
    endfunction

    function automatic logic [319:0] dut3_out();
        return {xp0, xp1, xp2, xp3, xp4};
    endfunction

    task automatic drive_x(input logic [319:0] s);
        {xi0, xi1, xi2, xi3, xi4} = s;
    endtask

    task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One operation on the UNROLL=2 instance; prev is what the outputs showed beforehand.
    task automatic run_op(input string tag, input logic [3:0] n, input logic [319:0] s_in,
                          input logic [319:0] prev, output logic [319:0] res);
        int          done_at;
        int          busy_cnt;
        int          err_seen;
        logic [319:0] exp_mid;
        @(negedge clk);
        start = 1'b1;
        nr    = n;
        drive_x(s_in);
        done_at  = -1;
        busy_cnt = 0;
        err_seen = 0;
        res      = perm_model(s_in, 12 - int'(n), int'(n));
        for (int e = 1; e <= 30 && done_at < 0; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (err === 1'b1) err_seen++;
            if (done === 1'b1) begin
                done_at = e;
            end else if (busy === 1'b1) begin
                busy_cnt++;
`ifdef ASCON_PERM_OUTPUT_GATE_EN
                exp_mid = prev;
`else
                exp_mid = perm_model(s_in, 12 - int'(n), 2 * (e - 1));
`endif
                check_val({tag, "_mid"}, dut_out(), exp_mid);
            end
        end
        check_int({tag, "_latency"}, done_at, int'(n) / 2 + 1);
        check_int({tag, "_busy_cycles"}, busy_cnt, int'(n) / 2);
        check_int({tag, "_err_seen"}, err_seen, 0);
        check_val({tag, "_result"}, dut_out(), res);
        @(posedge clk); #1;
        check_bit({tag, "_done_drop"}, done, 1'b0);
        check_val({tag, "_hold"}, dut_out(), res);
    endtask

    initial begin
        logic [319:0] iv_state, r_zero, r_iv12, r_iv6, r_rst;
        int           d3, dcount, first_d, second_d, err_seen;
        iv_state = {IV, 256'd0};
        rst    = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        nr     = 4'd0;
        nr3    = 4'd0;
        drive_x(320'd0);
        #1 rst = 1'b1;
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_val("rst_out", dut_out(), 320'd0);
        check_val("rst_out_u3", dut3_out(), 320'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero state, p12; then the Ascon-128 IV, p12 then p6 on its result.
        run_op("zero_p12", 4'd12, 320'd0, 320'd0, r_zero);
        run_op("iv_p12", 4'd12, iv_state, r_zero, r_iv12);
        run_op("iv_p6", 4'd6, r_iv12, r_iv12, r_iv6);

        // Illegal nr=0 and odd nr=5 on the UNROLL=2 instance.
        @(negedge clk);
        start = 1'b1; nr = 4'd0; drive_x({4{80'h1234_5678_9abc_def0_0f1e}});
        @(posedge clk); #1;
        start = 1'b0;
        check_bit("nr0_err", err, 1'b1);
        check_bit("nr0_busy", busy, 1'b0);
        check_val("nr0_out", dut_out(), r_iv6);
        @(posedge clk); #1;
        check_bit("nr0_err_pulse", err, 1'b0);
        check_bit("nr0_busy_after", busy, 1'b0);
        @(negedge clk);
        start = 1'b1; nr = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check_bit("nr5_err", err, 1'b1);
        check_val("nr5_out", dut_out(), r_iv6);

        // UNROLL=3: nr=8 rejected, nr=6 accepted with 3-cycle latency.
        @(negedge clk);
        start3 = 1'b1; nr3 = 4'd8;
        @(posedge clk); #1;
        start3 = 1'b0;
        check_bit("u3_nr8_err", err3, 1'b1);
        check_bit("u3_nr8_busy", busy3, 1'b0);
        check_val("u3_nr8_out", dut3_out(), 320'd0);
        @(posedge clk); #1;
        check_bit("u3_nr8_err_pulse", err3, 1'b0);
        @(negedge clk);
        start3 = 1'b1; nr3 = 4'd6; drive_x(iv_state);
        d3 = -1;
        for (int e = 1; e <= 12 && d3 < 0; e++) begin
            @(posedge clk); #1;
            start3 = 1'b0;
            if (done3 === 1'b1) d3 = e;
        end
        check_int("u3_p6_latency", d3, 3);
        check_val("u3_p6_result", dut3_out(), perm_model(iv_state, 6, 6));

        // start held high: one op per IDLE window, done pulses 8 cycles apart.
        @(negedge clk);
        start = 1'b1; nr = 4'd12; drive_x(iv_state);
        dcount = 0; first_d = -1; second_d = -1; err_seen = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk); #1;
            if (e == 16) start = 1'b0;
            if (err === 1'b1) err_seen++;
            if (done === 1'b1) begin
                dcount++;
                if (first_d < 0) first_d = e;
                else if (second_d < 0) second_d = e;
            end
        end
        check_int("hold_done_count", dcount, 2);
        check_int("hold_first_latency", first_d, 7);
        check_int("hold_done_spacing", second_d - first_d, 8);
        check_int("hold_err_seen", err_seen, 0);
        check_val("hold_result", dut_out(), r_iv12);
        check_bit("hold_busy_idle", busy, 1'b0);

        // Async reset during the third RUN cycle.
        @(negedge clk);
        start = 1'b1; nr = 4'd12; drive_x(iv_state);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_bit("rst_mid_busy_before", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_bit("rst_mid_busy", busy, 1'b0);
        check_bit("rst_mid_done", done, 1'b0);
        check_bit("rst_mid_err", err, 1'b0);
        check_val("rst_mid_out", dut_out(), 320'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        check_int("rst_mid_no_done", dcount, 0);
        run_op("after_rst_p12", 4'd12, iv_state, 320'd0, r_rst);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
